// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath and its stream controller:
// default sizes, operand/accumulator types and the controller FSM states.
package mac_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  typedef logic signed [DEF_WIDTH-1:0]   op_t;
  typedef logic signed [2*DEF_WIDTH-1:0] acc_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/mac_stream_ctrl_if.sv
// Bundle of buffer-write, start, MAC operand and result-handshake signals.
// master = the stream controller, slave = the surrounding layer/MAC side.
interface mac_stream_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                      wr_en;
  logic [AW-1:0]             wr_addr;
  logic signed [WIDTH-1:0]   wr_w;
  logic signed [WIDTH-1:0]   wr_x;
  logic                      start;
  logic [AW:0]               len;
  logic                      busy;
  logic                      mac_clr;
  logic                      mac_en;
  logic signed [WIDTH-1:0]   mac_w;
  logic signed [WIDTH-1:0]   mac_x;
  logic signed [2*WIDTH-1:0] mac_acc;
  logic                      res_valid;
  logic                      res_ready;
  logic [WIDTH-1:0]          res_data;

  modport master (
    input  wr_en, wr_addr, wr_w, wr_x, start, len, mac_acc, res_ready,
    output busy, mac_clr, mac_en, mac_w, mac_x, res_valid, res_data
  );

  modport slave (
    output wr_en, wr_addr, wr_w, wr_x, start, len, mac_acc, res_ready,
    input  busy, mac_clr, mac_en, mac_w, mac_x, res_valid, res_data
  );

endinterface

// File: rtl/mac_stream_ctrl_relu.sv
// relu_narrow: combinational 2N -> N ReLU. With RELU_SAT_EN defined, positive
// values above 2^N-1 saturate to all-ones; otherwise they are truncated.
module relu_narrow #(
  parameter int WIDTH = 8
) (
  input  logic signed [2*WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0]          res_o
);

  logic positive;
  assign positive = !acc_i[2*WIDTH-1] && (|acc_i);

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    res_o = '0;
    if (positive) begin
`ifdef RELU_SAT_EN
      if (|acc_i[2*WIDTH-1:WIDTH]) res_o = '1;
      else                         res_o = acc_i[WIDTH-1:0];
`else
      res_o = acc_i[WIDTH-1:0];
`endif
    end
  end

endmodule

// File: rtl/mac_stream_ctrl.sv
// Streams buffered (w, x) pairs into the MAC, then returns ReLU(acc) over
// valid/ready. Optional saturation in relu_narrow via RELU_SAT_EN.
module mac_stream_ctrl
  import mac_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  mac_stream_ctrl_if.master bus
);

  logic signed [WIDTH-1:0] buf_w [DEPTH];
  logic signed [WIDTH-1:0] buf_x [DEPTH];

  state_e                  state_q;
  logic [AW-1:0]           idx_q;
  logic [AW:0]             len_q;
  logic                    busy_q;
  logic                    clr_q;
  logic                    en_q;
  logic                    valid_q;
  logic signed [WIDTH-1:0] w_q;
  logic signed [WIDTH-1:0] x_q;
  logic [WIDTH-1:0]        res_q;

  logic [AW:0]             len_d;
  logic [AW-1:0]           idx_d;
  logic                    last_d;
  logic [WIDTH-1:0]        relu_d;

  assign len_d  = (bus.len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.len;
  assign idx_d  = idx_q + AW'(1);
  assign last_d = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));

  relu_narrow #(.WIDTH(WIDTH)) u_relu (
    .acc_i (bus.mac_acc),
    .res_o (relu_d)
  );

  // NOTE: the pair buffer is plain storage with no reset; only control state is reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy_q) begin
      buf_w[bus.wr_addr] <= bus.wr_w;
      buf_x[bus.wr_addr] <= bus.wr_x;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      w_q     <= '0;
      x_q     <= '0;
      res_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            clr_q   <= 1'b1;
            idx_q   <= '0;
            len_q   <= len_d;
          end
        end
        CLEAR: begin
          clr_q <= 1'b0;
          idx_q <= '0;
          if (len_q != '0) begin
            state_q <= STREAM;
            en_q    <= 1'b1;
            w_q     <= buf_w[0];
            x_q     <= buf_x[0];
          end else begin
            state_q <= DRAIN;
          end
        end
        STREAM: begin
          // Outputs already carry pair idx_q; stop once the last pair is on the bus.
          if (last_d) begin
            en_q    <= 1'b0;
            state_q <= DRAIN;
          end else begin
            idx_q <= idx_d;
            w_q   <= buf_w[idx_d];
            x_q   <= buf_x[idx_d];
          end
        end
        DRAIN: begin
          res_q   <= relu_d;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.mac_clr   = clr_q;
  assign bus.mac_en    = en_q;
  assign bus.mac_w     = w_q;
  assign bus.mac_x     = x_q;
  assign bus.res_valid = valid_q;
  assign bus.res_data  = res_q;

endmodule

// File: tb/tb_mac_stream_ctrl.sv
// Self-checking bench for mac_stream_ctrl with a behavioural MAC and a
// result scoreboard queue; expected ReLU values follow RELU_SAT_EN.
module tb_mac_stream_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_stream_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  mac_stream_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Behavioural MAC: synchronous clear, accumulate on enable.
  logic signed [2*WIDTH-1:0] acc_m = '0;
  always @(posedge clk) begin
    if (bus.mac_clr)     acc_m <= '0;
    else if (bus.mac_en) acc_m <= acc_m + bus.mac_w * bus.mac_x;
  end
  assign bus.mac_acc = acc_m;

  int errors = 0;
  int checks = 0;

  logic signed [WIDTH-1:0] sh_w [DEPTH];
  logic signed [WIDTH-1:0] sh_x [DEPTH];
  logic [WIDTH-1:0]        res_sb [$];

  task automatic load_pair(input int addr, input int w, input int x);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(addr);
    bus.wr_w    = 8'(w);
    bus.wr_x    = 8'(x);
    sh_w[addr]  = 8'(w);
    sh_x[addr]  = 8'(x);
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  // Start one evaluation and check cycle-exact behaviour through the handshake.
  task automatic run_neuron(input string name, input int len_in, input logic [7:0] exp_res,
                            input int hold, input logic ready_early);
    int n;
    logic [7:0] exp_q;
    n = (len_in > DEPTH) ? DEPTH : len_in;
    res_sb.push_back(exp_res);
    bus.res_ready = ready_early;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 5'(len_in);
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if ({bus.mac_clr, bus.mac_en, bus.busy} !== 3'b101) begin
      errors++;
      $display("FAIL %s clr_cycle: clr/en/busy=%b%b%b want 101", name, bus.mac_clr, bus.mac_en, bus.busy);
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++;
      if (bus.mac_en !== 1'b1 || bus.mac_clr !== 1'b0 || bus.mac_w !== sh_w[k] || bus.mac_x !== sh_x[k]) begin
        errors++;
        $display("FAIL %s pair%0d: en=%b clr=%b w=%0d x=%0d want en=1 clr=0 w=%0d x=%0d",
                 name, k, bus.mac_en, bus.mac_clr, bus.mac_w, bus.mac_x, sh_w[k], sh_x[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.mac_en !== 1'b0 || bus.res_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s drain: en=%b valid=%b busy=%b want 0 0 1", name, bus.mac_en, bus.res_valid, bus.busy);
    end
    @(negedge clk);
    exp_q = res_sb.pop_front();
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== exp_q) begin
      errors++;
      $display("FAIL %s result: valid=%b data=%0d want valid=1 data=%0d", name, bus.res_valid, bus.res_data, exp_q);
    end
    if (!ready_early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== exp_q || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL %s hold%0d: valid=%b data=%0d busy=%b want 1 %0d 1",
                   name, h, bus.res_valid, bus.res_data, bus.busy, exp_q);
        end
        if (h == 1) begin
          bus.start   = 1'b1;
          bus.len     = 5'd2;
          bus.wr_en   = 1'b1;
          bus.wr_addr = 4'd0;
          bus.wr_w    = 8'sd99;
          bus.wr_x    = 8'sd99;
        end else if (h == 2) begin
          bus.start = 1'b0;
          bus.wr_en = 1'b0;
        end
      end
      bus.res_ready = 1'b1;
    end
    @(negedge clk);
    bus.res_ready = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.mac_en !== 1'b0) begin
      errors++;
      $display("FAIL %s release: busy=%b valid=%b en=%b want 000", name, bus.busy, bus.res_valid, bus.mac_en);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.mac_clr !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: busy=%b clr=%b want 00", name, bus.busy, bus.mac_clr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_w = '0; bus.wr_x = '0;
    bus.start = 1'b0; bus.len = '0; bus.res_ready = 1'b0;
    #12;
    checks++;
    if ({bus.busy, bus.mac_clr, bus.mac_en, bus.res_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/clr/en/valid=%b%b%b%b want 0000", bus.busy, bus.mac_clr, bus.mac_en, bus.res_valid);
    end
    checks++;
    if (bus.mac_w !== 8'd0 || bus.mac_x !== 8'd0 || bus.res_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: w=%0d x=%0d res=%0d want 0 0 0", bus.mac_w, bus.mac_x, bus.res_data);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    load_pair(0, 3, 4);
    load_pair(1, -2, 5);
    load_pair(2, 1, 1);
    run_neuron("basic", 3, 8'd3, 0, 1'b0);
  endtask

  task automatic test_negative();
    load_pair(0, -4, 4);
    load_pair(1, 1, 2);
    run_neuron("negative", 2, 8'd0, 0, 1'b0);
  endtask

  task automatic test_saturation();
    load_pair(0, 127, 127);
    load_pair(1, 127, 127);
`ifdef RELU_SAT_EN
    run_neuron("saturate", 2, 8'd255, 0, 1'b0);
`else
    run_neuron("truncate", 2, 8'd2, 0, 1'b0);
`endif
  endtask

  task automatic test_len_zero();
    run_neuron("len_zero", 0, 8'd0, 0, 1'b1);
  endtask

  task automatic test_done_hold();
    load_pair(0, 3, 4);
    load_pair(1, -2, 5);
    load_pair(2, 1, 1);
    run_neuron("done_hold", 3, 8'd3, 5, 1'b0);
    run_neuron("buf_intact", 3, 8'd3, 0, 1'b1);
  endtask

  task automatic test_len_clamp();
    for (int i = 0; i < DEPTH; i++) load_pair(i, 1, 1);
    run_neuron("len_clamp", 20, 8'd16, 0, 1'b1);
  endtask

  task automatic test_reset_mid_stream();
    for (int i = 0; i < 8; i++) load_pair(i, i + 1, 2);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 5'd8;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) @(negedge clk);
    checks++;
    if (bus.mac_en !== 1'b1 || bus.mac_w !== 8'sd5) begin
      errors++;
      $display("FAIL mid_stream: en=%b w=%0d want en=1 w=5", bus.mac_en, bus.mac_w);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.mac_clr, bus.mac_en, bus.res_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: busy/clr/en/valid=%b%b%b%b want 0000", bus.busy, bus.mac_clr, bus.mac_en, bus.res_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    load_pair(0, 2, 3);
    run_neuron("after_reset", 1, 8'd6, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_len_zero();
    test_done_hold();
    test_len_clamp();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
